// File: rtl/y86_bus_pkg.sv
// Shared types and defaults for the y86 memory-bus arbiter.
// The wait counter is sized from the TIMEOUT parameter of each instance.
package y86_bus_pkg;

  localparam int AW_DEF      = 32;
  localparam int DW_DEF      = 32;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Index of a requester: 0 = y86_seq core, 1 = debug/DMA loader.
  typedef logic port_t;

  // TIMEOUT is at least 2, so the counter is at least one bit wide.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout);
  endfunction

  localparam int CNT_W_DEF = $clog2(TIMEOUT_DEF);

endpackage

// File: rtl/y86_rr_pick.sv
// Combinational two-way picker: chooses which requester gets the bus next.
// On a conflict, round-robin favours the port that did not own the last transfer.
module y86_rr_pick
  import y86_bus_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] i_req,
  input  port_t      i_last,
  output port_t      o_winner,
  output logic       o_any
);

  always_comb begin
    o_winner = 1'b0;
    o_any    = |i_req;
    if (&i_req) begin
      o_winner = FIXED_PRIO ? 1'b0 : ~i_last;
    end else if (i_req[1]) begin
      o_winner = 1'b1;
    end
  end

endmodule

// File: rtl/y86_bus_arbiter.sv
// Two-requester arbiter and transfer sequencer for the y86 memory bus.
// Each transfer runs IDLE -> ACCESS (waits for mem_rdy or times out) -> RESP.
module y86_bus_arbiter
  import y86_bus_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_done,
  output logic          m1_done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_out,
  output logic          mem_WE,
  output logic          mem_RE,
  input  logic [DW-1:0] mem_in,
  input  logic          mem_rdy,
  output state_t        dbg_state
);

  localparam int          CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  // Handshake: a requester raises req and holds it until its done pulse;
  // req is sampled only in IDLE, and addr/we/wdata are captured at that same
  // edge, so later changes on either port have no effect on the transfer.

  state_t        r_state;
  port_t         r_port;
  port_t         r_last;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic [CW-1:0] r_cnt;

  state_t        w_next;
  logic          w_take;
  logic          w_timeout;
  port_t         w_winner;
  logic          w_any;
  logic          w_access;
  logic          w_resp;
  logic          w_busy;

  y86_rr_pick #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_pick (
    .i_req    ({m1_req, m0_req}),
    .i_last   (r_last),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  always_comb begin
    w_next    = r_state;
    w_take    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next = ACCESS;
          w_take = 1'b1;
        end
      end
      ACCESS: begin
        // A completion in the last allowed cycle still counts as success.
        if (mem_rdy) begin
          w_next = RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_next    = RESP;
          w_timeout = 1'b1;
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_port  <= 1'b0;
      r_last  <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_take) begin
        r_port <= w_winner;
        if (w_winner) begin
          r_we    <= m1_we;
          r_addr  <= m1_addr;
          r_wdata <= m1_wdata;
        end else begin
          r_we    <= m0_we;
          r_addr  <= m0_addr;
          r_wdata <= m0_wdata;
        end
      end
      if (r_state == ACCESS) begin
        r_cnt <= r_cnt + 1'b1;
        if (mem_rdy) begin
          r_err <= 1'b0;
          if (!r_we) begin
            r_rdata <= mem_in;
          end
        end else if (w_timeout) begin
          r_err <= 1'b1;
        end
      end
      if (r_state == RESP) begin
        r_last <= r_port;
        r_cnt  <= '0;
      end
    end
  end

  assign w_access = (r_state == ACCESS);
  assign w_resp   = (r_state == RESP);
  assign w_busy   = w_access | w_resp;

  assign m0_gnt   = w_busy & ~r_port;
  assign m1_gnt   = w_busy &  r_port;
  assign m0_done  = w_resp & ~r_port;
  assign m1_done  = w_resp &  r_port;
  assign err      = w_resp &  r_err;
  assign rdata    = r_rdata;

  assign mem_A    = w_access ? r_addr  : '0;
  assign mem_out  = w_access ? r_wdata : '0;
  assign mem_WE   = w_access &  r_we;
  assign mem_RE   = w_access & ~r_we;

  assign dbg_state = r_state;

endmodule
